// File: rtl/dual_rail_pkg.sv
//------------------------------------------------------------------------------
// Module  : dual_rail_pkg
// Brief   : Shared FSM encoding and counter width for the dual-rail receiver.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package dual_rail_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RTZ  = 2'd2
  } rcv_state_t;

  localparam int XFER_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/dual_sync.sv
//------------------------------------------------------------------------------
// Module  : dual_sync
// Brief   : width x sync_stages flop synchronizer for one bundle of rails.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dual_sync #(
  parameter int width       = 8,
  parameter int sync_stages = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] r_stage [sync_stages];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < sync_stages; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < sync_stages; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[sync_stages-1];

endmodule

`default_nettype wire

// File: rtl/dual_act_rcv.sv
//------------------------------------------------------------------------------
// Module  : dual_act_rcv
// Brief   : Active-side four-phase dual-rail receiver with valid/ready output.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dual_act_rcv
  import dual_rail_pkg::*;
#(
  parameter int width       = 8,
  parameter int sync_stages = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  req,
  input  logic [width-1:0]      ack_d0,
  input  logic [width-1:0]      ack_d1,
  output logic [width-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  err,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  logic [width-1:0]       w_s0;
  logic [width-1:0]       w_s1;
  logic                   w_complete;
  logic                   w_empty;
  logic                   w_clash;
  logic                   w_slot_free;
  rcv_state_t             r_state;
  logic [sync_stages-1:0] r_primed;

  dual_sync #(.width(width), .sync_stages(sync_stages)) u_sync_d0 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ack_d0),
    .q       (w_s0)
  );

  dual_sync #(.width(width), .sync_stages(sync_stages)) u_sync_d1 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ack_d1),
    .q       (w_s1)
  );

  assign w_complete  = &(w_s0 | w_s1);
  assign w_empty     = ~|(w_s0 | w_s1);
  assign w_clash     = |(w_s0 & w_s1);
  assign w_slot_free = !dout_valid || dout_ready;

  // Synchronizers reset to zero and would fake "empty" until the real rail
  // state has propagated; r_primed blocks a request until they are flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_primed   <= '0;
      req        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
      xfer_cnt   <= '0;
    end else begin
      r_primed <= {r_primed[sync_stages-2:0], 1'b1};
      if (dout_valid && dout_ready) dout_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_primed[sync_stages-1] && w_empty && w_slot_free) begin
            r_state <= REQ;
            req     <= 1'b1;
          end
        end
        REQ: begin
          if (w_complete) begin
            dout       <= w_s1;
            dout_valid <= 1'b1;
            if (w_clash) err <= 1'b1;
            req        <= 1'b0;
            r_state    <= RTZ;
          end
        end
        RTZ: begin
          if (w_empty) begin
            xfer_cnt <= xfer_cnt + XFER_CNT_W'(1);
            r_state  <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          req     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dual_act_rcv.sv
//------------------------------------------------------------------------------
// Module  : tb_dual_act_rcv
// Brief   : Directed self-checking bench for dual_act_rcv.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dual_act_rcv;

  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req;
  logic [W-1:0] ack_d0;
  logic [W-1:0] ack_d1;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         err;
  logic [15:0]  xfer_cnt;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [7:0]   got;
  logic         stale_req;

  always #5 clk = ~clk;

  dual_act_rcv #(.width(W), .sync_stages(SS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .ack_d0     (ack_d0),
    .ack_d1     (ack_d1),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .err        (err),
    .xfer_cnt   (xfer_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic lvl, input int budget);
    int n = 0;
    while (req !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, req}, {31'd0, lvl});
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (dout_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, dout_valid}, 32'd1);
  endtask

  // Acts as the passive source for one word; called at a negedge.
  task automatic xfer(input string tag, input logic [7:0] d1, input logic [7:0] d0,
                      output logic [7:0] data);
    wait_req({tag, " req_hi"}, 1'b1, 20);
    ack_d1 = d1;
    ack_d0 = d0;
    wait_valid({tag, " valid"}, 20);
    data = dout;
    check({tag, " req_lo"}, {31'd0, req}, 32'd0);
    ack_d1 = '0;
    ack_d0 = '0;
    repeat (SS + 2) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    dout_ready = 1'b1;
    ack_d0     = '0;
    ack_d1     = '0;
    repeat (2) @(negedge clk);
    check("rst req",   {31'd0, req},        32'd0);
    check("rst dout",  {24'd0, dout},       32'd0);
    check("rst valid", {31'd0, dout_valid}, 32'd0);
    check("rst err",   {31'd0, err},        32'd0);
    check("rst cnt",   {16'd0, xfer_cnt},   32'd0);
    reset_n = 1'b1;

    // single transfer with exact latency
    wait_req("single req_hi", 1'b1, 20);
    ack_d1 = 8'hA5;
    ack_d0 = 8'h5A;
    repeat (SS) @(negedge clk);
    check("single early", {31'd0, dout_valid}, 32'd0);
    @(negedge clk);
    check("single valid", {31'd0, dout_valid}, 32'd1);
    check("single dout",  {24'd0, dout},       32'hA5);
    check("single req_lo", {31'd0, req},       32'd0);
    @(negedge clk);
    check("single valid_1cyc", {31'd0, dout_valid}, 32'd0);
    ack_d1 = '0;
    ack_d0 = '0;
    repeat (SS + 1) @(negedge clk);
    check("single cnt", {16'd0, xfer_cnt}, 32'd1);
    check("single err", {31'd0, err},      32'd0);
    check("single req_end", {31'd0, req},  32'd0);

    // backpressure
    dout_ready = 1'b0;
    xfer("bp1", 8'h3C, 8'hC3, got);
    check("bp1 dout", {24'd0, got}, 32'h3C);
    repeat (6) @(negedge clk);
    check("bp hold req",   {31'd0, req},        32'd0);
    check("bp hold dout",  {24'd0, dout},       32'h3C);
    check("bp hold valid", {31'd0, dout_valid}, 32'd1);
    check("bp hold cnt",   {16'd0, xfer_cnt},   32'd2);
    dout_ready = 1'b1;
    @(negedge clk);
    check("bp drain req",   {31'd0, req},        32'd1);
    check("bp drain valid", {31'd0, dout_valid}, 32'd0);
    xfer("bp2", 8'hC3, 8'h3C, got);
    check("bp2 dout", {24'd0, got},      32'hC3);
    check("bp2 cnt",  {16'd0, xfer_cnt}, 32'd3);

    // skewed rails, one bit per cycle
    wait_req("skew req_hi", 1'b1, 20);
    for (int i = 0; i < 7; i++) begin
      ack_d1[i] = 1'b1;
      @(negedge clk);
    end
    repeat (SS + 2) @(negedge clk);
    check("skew partial valid", {31'd0, dout_valid}, 32'd0);
    check("skew partial req",   {31'd0, req},        32'd1);
    ack_d1[7] = 1'b1;
    repeat (SS + 1) @(negedge clk);
    check("skew valid", {31'd0, dout_valid}, 32'd1);
    check("skew dout",  {24'd0, dout},       32'hFF);
    ack_d1 = '0;
    repeat (SS + 2) @(negedge clk);
    check("skew cnt", {16'd0, xfer_cnt}, 32'd4);

    // clash on bit 2, then clean words keep err sticky
    xfer("clash", 8'h04, 8'hFF, got);
    check("clash dout", {24'd0, got}, 32'h04);
    check("clash err",  {31'd0, err}, 32'd1);
    xfer("clean1", 8'h11, 8'hEE, got);
    check("clean1 dout", {24'd0, got}, 32'h11);
    xfer("clean2", 8'h22, 8'hDD, got);
    check("clean2 dout", {24'd0, got}, 32'h22);
    xfer("clean3", 8'h33, 8'hCC, got);
    check("clean3 dout", {24'd0, got},      32'h33);
    check("clean3 err",  {31'd0, err},      32'd1);
    check("clean3 cnt",  {16'd0, xfer_cnt}, 32'd8);

    // reset mid-handshake with a stale source
    wait_req("mid req_hi", 1'b1, 20);
    ack_d1 = 8'h77;
    ack_d0 = 8'h88;
    #2 reset_n = 1'b0;
    #1;
    check("mid req",   {31'd0, req},        32'd0);
    check("mid dout",  {24'd0, dout},       32'd0);
    check("mid valid", {31'd0, dout_valid}, 32'd0);
    check("mid err",   {31'd0, err},        32'd0);
    check("mid cnt",   {16'd0, xfer_cnt},   32'd0);
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    stale_req = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (req) stale_req = 1'b1;
    end
    check("stale no req",   {31'd0, stale_req},  32'd0);
    check("stale no valid", {31'd0, dout_valid}, 32'd0);
    ack_d1 = '0;
    ack_d0 = '0;
    xfer("post_rst", 8'h5A, 8'hA5, got);
    check("post_rst dout", {24'd0, got},      32'h5A);
    check("post_rst cnt",  {16'd0, xfer_cnt}, 32'd1);

    // counter wrap from a preloaded value
    @(negedge clk);
    force dut.xfer_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.xfer_cnt;
    xfer("wrap1", 8'hE1, 8'h1E, got);
    check("wrap1 dout", {24'd0, got},      32'hE1);
    check("wrap1 cnt",  {16'd0, xfer_cnt}, 32'hFFFF);
    xfer("wrap2", 8'h1E, 8'hE1, got);
    check("wrap2 dout", {24'd0, got},      32'h1E);
    check("wrap2 cnt",  {16'd0, xfer_cnt}, 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
